// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module   : cpu_types_pkg
// Brief    : Shared CPU types: machine word and instruction-cache FSM states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int c_word_bytes_w = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

endpackage

`default_nettype wire

// File: rtl/icache_tag_array.sv
// ============================================================================
// Module   : icache_tag_array
// Brief    : Valid/tag storage with bulk flush-clear and lookup compare.
// Revision : 1.0
// ============================================================================
`default_nettype none

module icache_tag_array #(
    parameter int SETS = 16,
    parameter int IDXW = 4,
    parameter int TAGW = 25
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            i_flush,
    input  logic [IDXW-1:0] i_rd_idx,
    input  logic [TAGW-1:0] i_rd_tag,
    output logic            o_hit,
    input  logic            i_wr_en,
    input  logic [IDXW-1:0] i_wr_idx,
    input  logic [TAGW-1:0] i_wr_tag
);

    logic [SETS-1:0] r_valid;
    logic [TAGW-1:0] r_tag [SETS];

    // Only the valid bits are reset; stale tags are harmless once invalid.
    always_ff @(posedge CLK) begin
        if (!nRST || i_flush) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx] <= i_wr_tag;
        end
    end

    assign o_hit = r_valid[i_rd_idx] & (r_tag[i_rd_idx] == i_rd_tag);

endmodule

`default_nettype wire

// File: rtl/icache_fill_unit.sv
// ============================================================================
// Module   : icache_fill_unit
// Brief    : Direct-mapped read-only I-cache with same-cycle hits and
//            multi-word block fills through memory_control.
// Revision : 1.0
// ============================================================================
`default_nettype none

module icache_fill_unit
    import cpu_types_pkg::*;
#(
    parameter int SETS     = 16,
    parameter int BLKWORDS = 2
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output logic  ihit,
    output word_t imemload,
    input  logic  iflush,
    output logic  iREN,
    output word_t iaddr,
    input  logic  iwait,
    input  word_t iload
);

    localparam int OFFW = $clog2(BLKWORDS);
    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 32 - c_word_bytes_w - OFFW - IDXW;
    localparam int CNTW = (OFFW > 0) ? OFFW : 1;
    localparam int AW   = IDXW + OFFW;

    icache_state_t   r_state, w_state_next;
    logic [CNTW-1:0] r_cnt, w_cnt_next;
    logic [TAGW-1:0] r_ftag;
    logic [IDXW-1:0] r_fidx;
    word_t           r_data [SETS*BLKWORDS];

    logic [TAGW-1:0] w_req_tag;
    logic [IDXW-1:0] w_req_idx;
    logic [AW-1:0]   w_rd_addr, w_wr_addr;
    logic            w_tag_hit, w_last, w_fill_start, w_accept, w_line_done;
    logic            w_tag_wr, w_in_fill;
    word_t           w_fill_addr;
    logic            w_unused_bits;

    assign w_req_tag     = imemaddr[31 -: TAGW];
    assign w_req_idx     = imemaddr[c_word_bytes_w+OFFW +: IDXW];
    assign w_unused_bits = ^imemaddr[c_word_bytes_w-1:0];

    generate
        if (OFFW > 0) begin : g_multi_word
            assign w_rd_addr   = {w_req_idx, imemaddr[c_word_bytes_w +: OFFW]};
            assign w_wr_addr   = {r_fidx, r_cnt};
            assign w_last      = (r_cnt == CNTW'(BLKWORDS - 1));
            assign w_fill_addr = {r_ftag, r_fidx, r_cnt, 2'b00};
        end else begin : g_single_word
            logic w_unused_cnt;
            assign w_unused_cnt = ^r_cnt;
            assign w_rd_addr    = w_req_idx;
            assign w_wr_addr    = r_fidx;
            assign w_last       = 1'b1;
            assign w_fill_addr  = {r_ftag, r_fidx, 2'b00};
        end
    endgenerate

    // Flush wins over a coincident final word so the line ends invalid.
    assign w_tag_wr = w_line_done & nRST & ~iflush;

    icache_tag_array #(
        .SETS (SETS),
        .IDXW (IDXW),
        .TAGW (TAGW)
    ) u_tags (
        .CLK      (CLK),
        .nRST     (nRST),
        .i_flush  (iflush),
        .i_rd_idx (w_req_idx),
        .i_rd_tag (w_req_tag),
        .o_hit    (w_tag_hit),
        .i_wr_en  (w_tag_wr),
        .i_wr_idx (r_fidx),
        .i_wr_tag (r_ftag)
    );

    always_ff @(posedge CLK) begin
        if (!nRST || iflush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_fill_start = 1'b0;
        w_accept     = 1'b0;
        w_line_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (imemREN && !w_tag_hit && !iflush) begin
                    w_state_next = FILL;
                    w_cnt_next   = '0;
                    w_fill_start = 1'b1;
                end
            end
            FILL: begin
                if (!iwait) begin
                    w_accept   = 1'b1;
                    w_cnt_next = w_last ? '0 : r_cnt + 1'b1;
                    if (w_last) begin
                        w_line_done  = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (w_fill_start) begin
            r_ftag <= w_req_tag;
            r_fidx <= w_req_idx;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_accept && nRST && !iflush) begin
            r_data[w_wr_addr] <= iload;
        end
    end

    // Outputs are gated by nRST so they read zero while reset is held.
    assign w_in_fill = nRST & (r_state == FILL);
    assign iREN      = w_in_fill;
    assign iaddr     = w_in_fill ? w_fill_addr : '0;
    assign ihit      = nRST & ~iflush & imemREN & w_tag_hit & (r_state == IDLE);
    assign imemload  = ihit ? r_data[w_rd_addr] : '0;

endmodule

`default_nettype wire
